// File: rtl/puf_response_voter_if.sv
// rtl/puf_response_voter_if.sv - bundle of signals between the PUF voter, the PUF array and the consumer
//
// Purpose: groups the request, PUF-array drive/response and voted-response
//          handshake signals of puf_response_voter into one interface.
// Optional: PUF_UNSTABLE_MASK_EN adds unstable_mask [7:0].
// Signals:
//   start, challenge[7:0], abort   request side (into the voter)
//   puf_c[7:0], puf_enable, puf_clr drive to the PUF array (from the voter)
//   puf_z[7:0]                      PUF array response (into the voter)
//   resp[7:0], resp_valid           voted response (from the voter)
//   resp_ready                      consumer accept (into the voter)
//   busy                            voter not idle (from the voter)
//   unstable_mask[7:0]              per-bit disagreement flags (optional)
// Modports:
//   slave  - the voter itself
//   master - the environment around it (requester, PUF array, consumer)

interface puf_response_voter_if;
  logic       start;
  logic [7:0] challenge;
  logic       abort;
  logic [7:0] puf_c;
  logic       puf_enable;
  logic       puf_clr;
  logic [7:0] puf_z;
  logic [7:0] resp;
  logic       resp_valid;
  logic       resp_ready;
  logic       busy;
`ifdef PUF_UNSTABLE_MASK_EN
  logic [7:0] unstable_mask;
`endif

  modport slave (
    input  start,
    input  challenge,
    input  abort,
    input  puf_z,
    input  resp_ready,
    output puf_c,
    output puf_enable,
    output puf_clr,
    output resp,
    output resp_valid,
    output busy
`ifdef PUF_UNSTABLE_MASK_EN
    ,
    output unstable_mask
`endif
  );

  modport master (
    output start,
    output challenge,
    output abort,
    output puf_z,
    output resp_ready,
    input  puf_c,
    input  puf_enable,
    input  puf_clr,
    input  resp,
    input  resp_valid,
    input  busy
`ifdef PUF_UNSTABLE_MASK_EN
    ,
    input  unstable_mask
`endif
  );
endinterface

// File: rtl/puf_response_voter.sv
// rtl/puf_response_voter.sv - repeated-evaluation majority voter for an 8-bit RO PUF array
//
// Purpose: on an accepted start, drives one challenge into the PUF array for
//          NUM_EVALS evaluations (clear pulse, enable window, settle, sample),
//          tallies each response bit and presents the per-bit majority as a
//          stable response over a valid/ready handshake.
// Optional: define PUF_UNSTABLE_MASK_EN to add unstable_mask, flagging bits
//           whose evaluations did not all agree.
// Parameters:
//   NUM_EVALS     evaluations per challenge, odd, 1..15
//   EVAL_CYCLES   cycles puf_enable is held per evaluation, 1..65535
//   SETTLE_CYCLES cycles between enable drop and sampling, 0..255
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    puf_response_voter_if.slave (request, PUF drive/response,
//          voted response handshake, busy)

module puf_response_voter #(
  parameter int NUM_EVALS     = 5,
  parameter int EVAL_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  puf_response_voter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_EVAL,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0]  NUM_EVALS_W = 4'(NUM_EVALS);
  localparam logic [3:0]  HALF_W      = 4'(NUM_EVALS / 2);
  localparam logic [15:0] EVAL_LAST   = 16'(EVAL_CYCLES - 1);
  // Only referenced when SETTLE_CYCLES > 0, so the wrap at zero is harmless.
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  puf_c_q;
  logic        puf_enable_q;
  logic        puf_clr_q;
  logic [7:0]  resp_q;
  logic        resp_valid_q;
  logic        busy_q;
  logic [3:0]  tally_q [8];
  logic [3:0]  eval_cnt_q;
  // Shared by the EVAL window and the SETTLE delay; they never overlap.
  logic [15:0] win_cnt_q;
`ifdef PUF_UNSTABLE_MASK_EN
  logic [7:0]  unstable_mask_q;
  logic [7:0]  unstable_d;
`endif

  // Tally including the response being sampled this cycle; the final vote is
  // taken from these so resp is ready on the same edge that enters DONE.
  logic [3:0]  tally_d [8];
  logic [7:0]  vote_d;
  logic        last_eval;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      tally_d[i] = tally_q[i] + {3'b000, bus.puf_z[i]};
      vote_d[i]  = (tally_d[i] > HALF_W);
    end
  end

`ifdef PUF_UNSTABLE_MASK_EN
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      unstable_d[i] = (tally_d[i] != 4'd0) && (tally_d[i] != NUM_EVALS_W);
    end
  end
`endif

  assign last_eval = ((eval_cnt_q + 4'd1) == NUM_EVALS_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      puf_c_q      <= 8'h00;
      puf_enable_q <= 1'b0;
      puf_clr_q    <= 1'b0;
      resp_q       <= 8'h00;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      eval_cnt_q   <= 4'd0;
      win_cnt_q    <= 16'd0;
      for (int i = 0; i < 8; i++) tally_q[i] <= 4'd0;
`ifdef PUF_UNSTABLE_MASK_EN
      unstable_mask_q <= 8'h00;
`endif
    end else if (state_q != S_IDLE && bus.abort) begin
      // Cancel: nothing partial is presented; resp keeps its previous value.
      state_q      <= S_IDLE;
      puf_enable_q <= 1'b0;
      puf_clr_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      eval_cnt_q   <= 4'd0;
      win_cnt_q    <= 16'd0;
      for (int i = 0; i < 8; i++) tally_q[i] <= 4'd0;
`ifdef PUF_UNSTABLE_MASK_EN
      unstable_mask_q <= 8'h00;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          // start together with abort is treated as a no-op.
          if (bus.start && !bus.abort) begin
            puf_c_q    <= bus.challenge;
            eval_cnt_q <= 4'd0;
            for (int i = 0; i < 8; i++) tally_q[i] <= 4'd0;
            puf_clr_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          puf_clr_q    <= 1'b0;
          puf_enable_q <= 1'b1;
          win_cnt_q    <= 16'd0;
          state_q      <= S_EVAL;
        end

        S_EVAL: begin
          if (win_cnt_q == EVAL_LAST) begin
            puf_enable_q <= 1'b0;
            win_cnt_q    <= 16'd0;
            state_q      <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
          end else begin
            win_cnt_q <= win_cnt_q + 16'd1;
          end
        end

        S_SETTLE: begin
          if (win_cnt_q == SETTLE_LAST) begin
            win_cnt_q <= 16'd0;
            state_q   <= S_SAMPLE;
          end else begin
            win_cnt_q <= win_cnt_q + 16'd1;
          end
        end

        S_SAMPLE: begin
          for (int i = 0; i < 8; i++) tally_q[i] <= tally_d[i];
          eval_cnt_q <= eval_cnt_q + 4'd1;
          if (last_eval) begin
            resp_q       <= vote_d;
            resp_valid_q <= 1'b1;
`ifdef PUF_UNSTABLE_MASK_EN
            unstable_mask_q <= unstable_d;
`endif
            state_q      <= S_DONE;
          end else begin
            puf_clr_q <= 1'b1;
            state_q   <= S_CLEAR;
          end
        end

        S_DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          puf_enable_q <= 1'b0;
          puf_clr_q    <= 1'b0;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.puf_c      = puf_c_q;
  assign bus.puf_enable = puf_enable_q;
  assign bus.puf_clr    = puf_clr_q;
  assign bus.resp       = resp_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.busy       = busy_q;
`ifdef PUF_UNSTABLE_MASK_EN
  assign bus.unstable_mask = unstable_mask_q;
`endif

endmodule

// File: tb/tb_puf_response_voter.sv
// tb/tb_puf_response_voter.sv - directed scoreboard bench for puf_response_voter

module tb_puf_response_voter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  puf_response_voter_if if0 ();
  puf_response_voter_if if1 ();

  puf_response_voter #(.NUM_EVALS(5), .EVAL_CYCLES(16), .SETTLE_CYCLES(2)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  puf_response_voter #(.NUM_EVALS(1), .EVAL_CYCLES(1), .SETTLE_CYCLES(0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  pat [5];
  logic [15:0] sb0 [$];
  logic [15:0] sb1 [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {resp, unstable_mask} from the first n entries of pat.
  function automatic logic [15:0] model(input int n);
    logic [7:0] r;
    logic [7:0] m;
    int         cnt;
    r = 8'h00;
    m = 8'h00;
    for (int b = 0; b < 8; b++) begin
      cnt = 0;
      for (int k = 0; k < n; k++) cnt += int'(pat[k][b]);
      r[b] = (cnt > n / 2);
      m[b] = (cnt != 0) && (cnt != n);
    end
    return {r, m};
  endfunction

  task automatic set_pat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] e);
    pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d; pat[4] = e;
  endtask

  // Start a request on dut0 and follow it to resp_valid. puf_z is switched to
  // pat[k] at the k-th clear pulse. If poke >= 0, a second start (challenge
  // 8'h22) is asserted for one cycle at that point.
  task automatic run0(input logic [7:0] ch, input int poke,
                      output int edges, output int clrs, output int bad);
    int run;
    run = 0; edges = 0; clrs = 0; bad = 0;
    sb0.push_back(model(5));
    if0.challenge = ch;
    if0.start     = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    while (!if0.resp_valid && edges < 2000) begin
      if (if0.puf_clr) begin
        if (clrs < 5) if0.puf_z = pat[clrs];
        clrs++;
      end
      if (if0.puf_enable) run++;
      else begin
        if (run != 0 && run != 16) bad++;
        run = 0;
      end
      if (edges == poke) begin
        if0.challenge = 8'h22;
        if0.start     = 1'b1;
      end else begin
        if0.start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    if0.start = 1'b0;
  endtask

  task automatic pop0(input string tag);
    logic [15:0] exp;
    exp = sb0.pop_front();
    check({tag, "_resp"}, {8'h00, if0.resp}, {8'h00, exp[15:8]});
`ifdef PUF_UNSTABLE_MASK_EN
    check({tag, "_mask"}, {8'h00, if0.unstable_mask}, {8'h00, exp[7:0]});
`endif
  endtask

  task automatic ack0(input string tag);
    if0.resp_ready = 1'b1;
    @(posedge clk); #1;
    if0.resp_ready = 1'b0;
    check({tag, "_ack_valid"}, 16'(if0.resp_valid), 16'h0);
    check({tag, "_ack_busy"}, 16'(if0.busy), 16'h0);
  endtask

  task automatic run1(input logic [7:0] z, input string tag);
    int          e;
    logic [15:0] exp;
    pat[0] = z;
    sb1.push_back(model(1));
    if1.puf_z     = z;
    if1.challenge = 8'hE7;
    if1.start     = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    e = 0;
    while (!if1.resp_valid && e < 50) begin
      @(posedge clk); #1;
      e++;
    end
    check({tag, "_latency"}, 16'(e), 16'd3);
    exp = sb1.pop_front();
    check({tag, "_resp"}, {8'h00, if1.resp}, {8'h00, exp[15:8]});
    check({tag, "_puf_c"}, {8'h00, if1.puf_c}, 16'h00E7);
    if1.resp_ready = 1'b1;
    @(posedge clk); #1;
    if1.resp_ready = 1'b0;
    check({tag, "_ack_valid"}, 16'(if1.resp_valid), 16'h0);
    check({tag, "_ack_busy"}, 16'(if1.busy), 16'h0);
  endtask

  initial begin
    int edges, clrs, bad, stable, e, vhigh;
    logic [7:0] held;

    reset = 1'b0;
    if0.start = 1'b0; if0.challenge = 8'h00; if0.abort = 1'b0;
    if0.puf_z = 8'h00; if0.resp_ready = 1'b0;
    if1.start = 1'b0; if1.challenge = 8'h00; if1.abort = 1'b0;
    if1.puf_z = 8'h00; if1.resp_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_puf_c", {8'h00, if0.puf_c}, 16'h0);
    check("rst_puf_enable", 16'(if0.puf_enable), 16'h0);
    check("rst_puf_clr", 16'(if0.puf_clr), 16'h0);
    check("rst_resp", {8'h00, if0.resp}, 16'h0);
    check("rst_resp_valid", 16'(if0.resp_valid), 16'h0);
    check("rst_busy", 16'(if0.busy), 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Stable response, latency, clear pulses, enable windows, held handshake
    set_pat(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    run0(8'hA5, -1, edges, clrs, bad);
    check("t1_latency", 16'(edges), 16'd100);
    check("t1_clr_pulses", 16'(clrs), 16'd5);
    check("t1_bad_windows", 16'(bad), 16'd0);
    check("t1_puf_c", {8'h00, if0.puf_c}, 16'h00A5);
    check("t1_busy", 16'(if0.busy), 16'h1);
    held = if0.resp;
    pop0("t1");
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (if0.resp_valid && if0.resp == held) stable++;
    end
    check("t1_hold_stable", 16'(stable), 16'd10);
    ack0("t1");

    // Majority with disagreement, started back-to-back after the handshake
    set_pat(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00);
    run0(8'h5C, -1, edges, clrs, bad);
    check("t2a_latency", 16'(edges), 16'd100);
    pop0("t2a");
    ack0("t2a");

    set_pat(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    run0(8'h6D, -1, edges, clrs, bad);
    check("t2b_latency", 16'(edges), 16'd100);
    pop0("t2b");
    ack0("t2b");

    // start and abort together in IDLE
    if0.start = 1'b1; if0.abort = 1'b1; if0.challenge = 8'h99;
    @(posedge clk); #1;
    if0.start = 1'b0; if0.abort = 1'b0;
    check("idle_abort_busy", 16'(if0.busy), 16'h0);
    check("idle_abort_puf_c", {8'h00, if0.puf_c}, 16'h006D);

    // Abort during the third EVAL
    if0.puf_z = 8'hFF;
    if0.challenge = 8'hC3;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    clrs = if0.puf_clr ? 1 : 0;
    e = 0;
    while (!(clrs == 3 && if0.puf_enable) && e < 2000) begin
      @(posedge clk); #1;
      e++;
      if (if0.puf_clr) clrs++;
    end
    check("abort_reached_eval3", 16'(e < 2000), 16'h1);
    if0.abort = 1'b1;
    @(posedge clk); #1;
    if0.abort = 1'b0;
    check("abort_enable", 16'(if0.puf_enable), 16'h0);
    check("abort_busy", 16'(if0.busy), 16'h0);
    check("abort_valid", 16'(if0.resp_valid), 16'h0);
    check("abort_resp_kept", {8'h00, if0.resp}, 16'h0000);
    vhigh = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (if0.resp_valid || if0.busy) vhigh++;
    end
    check("abort_stays_idle", 16'(vhigh), 16'd0);

    set_pat(8'h81, 8'h81, 8'h81, 8'h81, 8'h81);
    run0(8'h81, -1, edges, clrs, bad);
    check("t4_latency", 16'(edges), 16'd100);
    pop0("t4");
    ack0("t4");

    // Asynchronous reset mid-SETTLE
    if0.challenge = 8'h11;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    e = 0;
    while (!if0.puf_enable && e < 100) begin @(posedge clk); #1; e++; end
    while (if0.puf_enable && e < 100) begin @(posedge clk); #1; e++; end
    check("settle_reached", 16'(e < 100 && if0.busy), 16'h1);
    #2 reset = 1'b0;
    #1;
    check("arst_puf_c", {8'h00, if0.puf_c}, 16'h0);
    check("arst_resp", {8'h00, if0.resp}, 16'h0);
    check("arst_busy", 16'(if0.busy), 16'h0);
    check("arst_enable_clr_valid",
          16'({if0.puf_enable, if0.puf_clr, if0.resp_valid}), 16'h0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // start while busy is ignored
    set_pat(8'h24, 8'h24, 8'h24, 8'h24, 8'h24);
    run0(8'h11, 7, edges, clrs, bad);
    check("t5_latency", 16'(edges), 16'd100);
    check("t5_puf_c", {8'h00, if0.puf_c}, 16'h0011);
    pop0("t5");
    ack0("t5");
    check("t5_puf_c_after", {8'h00, if0.puf_c}, 16'h0011);

    // Single evaluation, no settle, one-cycle window
    run1(8'h6D, "n1a");
    run1(8'h92, "n1b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
